counter_bist_ctrl: RTL and testbench

Built-in self-test controller that sequences the 3-bit enable counter as a device under test. It resets the counter, then drives its enable from a selectable pattern source for a programmed number of cycles. A cycle-accurate golden model runs alongside and is compared against the counter output every cycle. The first mismatch is reported back to the fault-tracking flow.

---
 rtl/counter_bist_pkg.sv | 29 ++
 rtl/bist_lfsr.sv | 40 ++++
 rtl/counter_bist_ctrl.sv | 163 ++++++++++++++++
 tb/tb_counter_bist_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_bist_pkg.sv
// Shared types and constants for the counter BIST controller.
package counter_bist_pkg;

  localparam int                LFSR_W             = 8;
  localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT  = 8'hA5;
  // Feedback taps l[7], l[5], l[4], l[3].
  localparam logic [LFSR_W-1:0] LFSR_TAPS          = 8'b1011_1000;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    RUN,
    CHK,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    EN_ONES  = 2'b00,
    EN_ZEROS = 2'b01,
    EN_LFSR  = 2'b10,
    EN_ALT   = 2'b11
  } en_mode_e;

  // XOR of the tapped bits; shifted into bit 0 on each advance.
  function automatic logic lfsr_fb(input logic [LFSR_W-1:0] l);
    return ^(l & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/bist_lfsr.sv
// 8-bit Fibonacci LFSR used as the pseudo-random enable source.
module bist_lfsr
  import counter_bist_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic adv_i,
  output logic bit_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  // Next value: reload the seed, shift one step, or hold.
  always_comb begin
    // NOTE: default assignment first so every path drives lfsr_d (no latch).
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = SEED;
    end else if (adv_i) begin
      lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_fb(lfsr_q)};
    end
  end

  // Shift register state.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign bit_o = lfsr_q[0];

endmodule

// File: rtl/counter_bist_ctrl.sv
// BIST sequencer for the enable counter: clears it, drives a chosen enable
// pattern for num_cycles cycles, tracks a golden count and records the
// first divergence between golden and observed count.
module counter_bist_ctrl
  import counter_bist_pkg::*;
#(
  parameter int                CNT_W     = 3,
  parameter int                LEN_W     = 8,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] num_cycles,
  input  logic [1:0]       en_mode,
  output logic             dut_rst,
  output logic             dut_en,
  input  logic [CNT_W-1:0] dut_count,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [LEN_W-1:0] fail_idx,
  output logic [CNT_W-1:0] fail_exp,
  output logic [CNT_W-1:0] fail_obs
);

  state_e           state_q;
  logic [LEN_W-1:0] num_q;
  en_mode_e         mode_q;
  logic [CNT_W-1:0] exp_q;
  logic [CNT_W-1:0] exp_d;
  logic [LEN_W-1:0] idx_q;
  logic [LEN_W-1:0] idx_d;
  logic             fail_flag_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [LEN_W-1:0] fail_idx_q;
  logic [CNT_W-1:0] fail_exp_q;
  logic [CNT_W-1:0] fail_obs_q;

  logic             lfsr_bit;
  logic             lfsr_load;
  logic             lfsr_adv;
  logic             pattern_bit;
  logic             mismatch;

  // The LFSR is reseeded on every accepted start and steps only while the
  // pattern is being applied, so each test sees the same sequence.
  assign lfsr_load = (state_q == IDLE) && start;
  assign lfsr_adv  = (state_q == RUN);

  bist_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst),
    .load_i (lfsr_load),
    .adv_i  (lfsr_adv),
    .bit_o  (lfsr_bit)
  );

  // Enable pattern for the current stimulus index, decoded from registers only.
  always_comb begin
    pattern_bit = 1'b0;
    case (mode_q)
      EN_ONES:  pattern_bit = 1'b1;
      EN_ZEROS: pattern_bit = 1'b0;
      EN_LFSR:  pattern_bit = lfsr_bit;
      EN_ALT:   pattern_bit = ~idx_q[0];
      default:  pattern_bit = 1'b0;
    endcase
  end

  assign dut_rst = (state_q == CLR);
  assign dut_en  = (state_q == RUN) & pattern_bit;

  // The observed count reflects the stimulus of the previous cycle, which is
  // exactly what exp_q holds in RUN and CHK.
  assign mismatch = ((state_q == RUN) || (state_q == CHK)) && (dut_count != exp_q);

  // Golden model wraps modulo 2^CNT_W just like the counter.
  assign exp_d = exp_q + CNT_W'(dut_en);
  assign idx_d = idx_q + LEN_W'(1);

  // Sequencer, golden model and first-failure capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      num_q       <= '0;
      mode_q      <= EN_ONES;
      exp_q       <= '0;
      idx_q       <= '0;
      fail_flag_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_idx_q  <= '0;
      fail_exp_q  <= '0;
      fail_obs_q  <= '0;
    end else begin
      done_q <= 1'b0;

      // Only the first mismatch is recorded; the test still runs to the end.
      if (mismatch && !fail_flag_q) begin
        fail_flag_q <= 1'b1;
        fail_idx_q  <= idx_q;
        fail_exp_q  <= exp_q;
        fail_obs_q  <= dut_count;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            num_q       <= num_cycles;
            mode_q      <= en_mode_e'(en_mode);
            fail_flag_q <= 1'b0;
            fail_idx_q  <= '0;
            fail_exp_q  <= '0;
            fail_obs_q  <= '0;
            pass_q      <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= CLR;
          end
        end
        CLR: begin
          exp_q   <= '0;
          idx_q   <= '0;
          state_q <= (num_q != '0) ? RUN : CHK;
        end
        RUN: begin
          exp_q <= exp_d;
          idx_q <= idx_d;
          if (idx_q == num_q - LEN_W'(1)) begin
            state_q <= CHK;
          end
        end
        CHK: begin
          // Fold in this cycle's final compare before publishing the verdict.
          pass_q  <= ~(fail_flag_q | mismatch);
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail_idx = fail_idx_q;
  assign fail_exp = fail_exp_q;
  assign fail_obs = fail_obs_q;

endmodule

// File: tb/tb_counter_bist_ctrl.sv
// Self-checking bench for counter_bist_ctrl: a 3-bit counter (optionally with
// count[1] stuck at 0) is attached as the device under test, and each test's
// outcome is predicted from the enable pattern rules with plain arithmetic.
module tb_counter_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] num_cycles = '0;
  logic [1:0] en_mode = '0;
  logic       dut_rst;
  logic       dut_en;
  logic [2:0] dut_count;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] fail_idx;
  logic [2:0] fail_exp;
  logic [2:0] fail_obs;

  // Counter under test and optional stuck-at fault on its output bit 1.
  logic [2:0] cnt = '0;
  logic       stuck = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  // Reference predictions for the current test.
  bit en_seq [256];
  int m_pass, m_fidx, m_fexp, m_fobs, m_final;

  counter_bist_ctrl #(
    .CNT_W     (3),
    .LEN_W     (8),
    .LFSR_SEED (8'hA5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_cycles (num_cycles),
    .en_mode    (en_mode),
    .dut_rst    (dut_rst),
    .dut_en     (dut_en),
    .dut_count  (dut_count),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_idx   (fail_idx),
    .fail_exp   (fail_exp),
    .fail_obs   (fail_obs)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dut_rst) cnt <= '0;
    else if (dut_en) cnt <= cnt + 3'd1;
  end

  assign dut_count = stuck ? (cnt & 3'b101) : cnt;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Predict enable sequence, verdict, first failure and final observed count.
  task automatic predict(input int mode, input int num, input bit stk);
    logic [7:0] l;
    int acc;
    int tru;
    int ob;
    bit found;
    l = 8'hA5;
    for (int i = 0; i < num; i++) begin
      case (mode)
        0: en_seq[i] = 1'b1;
        1: en_seq[i] = 1'b0;
        2: en_seq[i] = l[0];
        default: en_seq[i] = (i % 2 == 0);
      endcase
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end
    acc = 0;
    found = 1'b0;
    m_pass = 1; m_fidx = 0; m_fexp = 0; m_fobs = 0; m_final = 0;
    for (int k = 0; k <= num; k++) begin
      tru = acc % 8;
      ob  = stk ? (tru & 5) : tru;
      if (!found && ob != tru) begin
        found = 1'b1;
        m_pass = 0; m_fidx = k; m_fexp = tru; m_fobs = ob;
      end
      m_final = ob;
      if (k < num) acc += int'(en_seq[k]);
    end
  endtask

  // One complete test; optionally pulse start again in cycle 'inj'.
  task automatic run_test(input int mode, input int num, input bit stk, input int inj);
    predict(mode, num, stk);
    stuck      = stk;
    en_mode    = mode[1:0];
    num_cycles = num[7:0];
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= num + 3; c++) begin
      check($sformatf("dut_rst m%0d n%0d c%0d", mode, num, c), dut_rst, c == 1);
      check($sformatf("dut_en m%0d n%0d c%0d", mode, num, c), dut_en,
            (c >= 2 && c <= num + 1) ? en_seq[c-2] : 1'b0);
      check($sformatf("busy m%0d n%0d c%0d", mode, num, c), busy, 1);
      check($sformatf("done m%0d n%0d c%0d", mode, num, c), done, c == num + 3);
      if (c == num + 3) begin
        check($sformatf("pass m%0d n%0d", mode, num), pass, m_pass);
        check($sformatf("fail_idx m%0d n%0d", mode, num), fail_idx, m_fidx);
        check($sformatf("fail_exp m%0d n%0d", mode, num), fail_exp, m_fexp);
        check($sformatf("fail_obs m%0d n%0d", mode, num), fail_obs, m_fobs);
        check($sformatf("final_count m%0d n%0d", mode, num), dut_count, m_final);
      end
      if (c == inj) begin
        start      = 1'b1;
        num_cycles = 8'($urandom_range(1, 255));
        en_mode    = 2'($urandom_range(0, 3));
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    check($sformatf("idle_busy m%0d n%0d", mode, num), busy, 0);
    check($sformatf("idle_done m%0d n%0d", mode, num), done, 0);
    check($sformatf("idle_dut_rst m%0d n%0d", mode, num), dut_rst, 0);
    check($sformatf("pass_hold m%0d n%0d", mode, num), pass, m_pass);
  endtask

  initial begin
    int mode;
    int num;
    int inj;
    bit stk;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_dut_rst", dut_rst, 0);
    check("rst_dut_en", dut_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_fail_idx", fail_idx, 0);
    check("rst_fail_exp", fail_exp, 0);
    check("rst_fail_obs", fail_obs, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed scenarios.
    run_test(0, 10, 1'b0, 0);   // all-ones, final count 2
    run_test(1, 5, 1'b0, 0);    // all-zeros
    run_test(0, 4, 1'b1, 0);    // stuck count[1]: fail at idx 2
    run_test(2, 4, 1'b0, 0);    // LFSR 1,0,1,0
    run_test(0, 0, 1'b0, 0);    // zero-length test
    run_test(0, 10, 1'b0, 5);   // start pulsed at RUN idx 3
    run_test(3, 1, 1'b0, 4);    // start pulsed during DONE

    // Reset in the middle of RUN.
    stuck      = 1'b0;
    en_mode    = 2'b00;
    num_cycles = 8'd10;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_dut_en", dut_en, 1);
    rst = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_dut_en", dut_en, 0);
    check("midrst_dut_rst", dut_rst, 0);
    check("midrst_done", done, 0);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      check($sformatf("post_rst_done c%0d", i), done, 0);
      check($sformatf("post_rst_busy c%0d", i), busy, 0);
    end
    run_test(3, 6, 1'b0, 0);    // alternating, final count 3

    // Boundaries: longest test, faulty LFSR run after reseed.
    run_test(2, 255, 1'b0, 0);
    run_test(2, 7, 1'b1, 0);

    // Randomized tests.
    for (int t = 0; t < 30; t++) begin
      mode = int'($urandom_range(0, 3));
      num  = int'($urandom_range(0, 24));
      stk  = ($urandom_range(0, 2) == 0);
      inj  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, num + 3)) : 0;
      run_test(mode, num, stk, inj);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
